// File: rtl/trace_item_collector.sv
// trace_item_collector: captures filtered trace items into a FIFO and
// streams them out as AXI-Stream style packets of PACKET_ITEMS beats.
//
// Ports:
//   clk, rst_n       clock; synchronous active-low reset
//   en               capture enable
//   pc_valid         trace item valid this cycle
//   drop_instr       filter verdict, 1 = discard item
//   pc, instr        item payload
//   flush            pulse: close the current packet early
//   m_tdata          {pc, instr} of the output beat
//   m_tvalid         output beat valid
//   m_tready         consumer ready
//   m_tlast          last beat of the packet
//   fifo_count       items held, including the output beat
//   overflow         sticky: an item was lost while full
//
// Optional feature macro: TRACE_OVERFLOW_MARKER_EN
//   When defined, items lost while full are counted and reported in-band
//   by a marker item {pc = all ones, instr = loss count} as soon as a
//   slot frees up. When undefined no marker logic exists.

module trace_item_collector #(
    parameter int PC_WIDTH     = 64,
    parameter int INSTR_WIDTH  = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int PACKET_ITEMS = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            pc_valid,
    input  logic                            drop_instr,
    input  logic [PC_WIDTH-1:0]             pc,
    input  logic [INSTR_WIDTH-1:0]          instr,
    input  logic                            flush,
    output logic [PC_WIDTH+INSTR_WIDTH-1:0] m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow
);

    localparam int DW = PC_WIDTH + INSTR_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (PACKET_ITEMS > 1) ? $clog2(PACKET_ITEMS) : 1;

    localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);
    localparam logic [PW-1:0] ZERO_P  = '0;
    localparam logic [CW-1:0] LAST_C  = CW'(PACKET_ITEMS - 1);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    // Storage and pointers. Pointers carry one extra wrap bit so that
    // full (difference == depth) and empty (difference == 0) differ.
    logic [DW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;

    // Packet framing state.
    logic [CW-1:0] r_beat;
    logic          r_flush_pend;
    logic [PW-1:0] r_flush_left;
    logic          r_overflow;

    logic          w_cap;
    logic          w_pop;
    logic          w_valid;
    logic          w_room;
    logic          w_lost;
    logic          w_wr;
    logic          w_last;
    logic          w_flush_hit;
    logic [PW-1:0] w_count;
    logic [PW-1:0] w_left_after;
    logic [PW-1:0] w_pop_p;
    logic [DW-1:0] w_wdata;

    assign w_count = r_wptr - r_rptr;
    assign w_valid = (w_count != ZERO_P);
    assign w_pop   = w_valid && m_tready;
    assign w_cap   = en && pc_valid && !drop_instr;

    // A pop on the same edge frees the slot the write needs.
    assign w_room  = (w_count != DEPTH_P) || w_pop;
    assign w_lost  = w_cap && !w_room;

    assign w_last  = w_valid &&
                     ((r_beat == LAST_C) ||
                      (r_flush_pend && (r_flush_left == ONE_P)));

    // Items that remain after this edge's pop; these are the beats a
    // flush at this edge has to close out.
    assign w_pop_p      = w_pop ? ONE_P : ZERO_P;
    assign w_left_after = w_count - w_pop_p;

    // If the only held beat leaves at the flush edge there is nothing
    // left to terminate, so the flush is treated as ignored.
    assign w_flush_hit  = flush && (w_left_after != ZERO_P);

`ifdef TRACE_OVERFLOW_MARKER_EN
    localparam logic [INSTR_WIDTH-1:0] LOSS_MAX = '1;
    localparam logic [INSTR_WIDTH-1:0] LOSS_ONE = INSTR_WIDTH'(1);

    logic [INSTR_WIDTH-1:0] r_loss;
    logic                   w_mark;

    // A real capture wins the free slot; the marker waits for the
    // next edge with room and no capture.
    assign w_mark  = !w_cap && w_room && (r_loss != '0);
    assign w_wr    = (w_cap && w_room) || w_mark;
    assign w_wdata = w_mark ? {{PC_WIDTH{1'b1}}, r_loss}
                            : {pc, instr};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_loss <= '0;
        end else if (w_mark) begin
            r_loss <= '0;
        end else if (w_lost && (r_loss != LOSS_MAX)) begin
            r_loss <= r_loss + LOSS_ONE;
        end
    end
`else
    assign w_wr    = w_cap && w_room;
    assign w_wdata = {pc, instr};
`endif

    // Payload RAM needs no reset: the output is gated by m_tvalid.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + ONE_P;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ONE_P;
            end
        end
    end

    // Beat counter and flush tracking. A flush snapshots how many items
    // are held and the packet ends after exactly that many beats, so
    // items captured later fall into the following packet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_flush_left <= '0;
        end else begin
            if (w_pop) begin
                if (w_last) begin
                    r_beat       <= '0;
                    r_flush_pend <= 1'b0;
                end else begin
                    r_beat <= r_beat + ONE_C;
                    if (r_flush_pend) begin
                        r_flush_left <= r_flush_left - ONE_P;
                    end
                end
            end
            if (w_flush_hit) begin
                r_flush_pend <= 1'b1;
                r_flush_left <= w_left_after;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_lost) begin
            r_overflow <= 1'b1;
        end
    end

    assign m_tvalid   = w_valid;
    assign m_tdata    = w_valid ? r_mem[r_rptr[AW-1:0]] : '0;
    assign m_tlast    = w_last;
    assign fifo_count = w_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_trace_item_collector.sv
// Testbench for trace_item_collector: randomized stimulus checked
// against a queue-based reference model of the collector.

module tb_trace_item_collector;

    localparam int PW    = 64;
    localparam int IW    = 32;
    localparam int DEPTH = 16;
    localparam int PKT   = 8;
    localparam int DW    = PW + IW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          pc_valid;
    logic          drop_instr;
    logic [PW-1:0] pc;
    logic [IW-1:0] instr;
    logic          flush;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [4:0]    fifo_count;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trace_item_collector #(
        .PC_WIDTH     (PW),
        .INSTR_WIDTH  (IW),
        .FIFO_DEPTH   (DEPTH),
        .PACKET_ITEMS (PKT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pc_valid   (pc_valid),
        .drop_instr (drop_instr),
        .pc         (pc),
        .instr      (instr),
        .flush      (flush),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    // Reference model: a queue of held items plus packet bookkeeping.
    logic [DW-1:0] mq[$];
    int            m_beats;
    int            m_fl;
    longint        m_loss;
    bit            m_ovf;

    always @(posedge clk) begin : model
        int n0;
        bit pop;
        bit lst;
        bit cap;
        bit room;
        logic [IW-1:0] lv;
        if (!rst_n) begin
            mq.delete();
            m_beats = 0;
            m_fl    = 0;
            m_loss  = 0;
            m_ovf   = 1'b0;
        end else begin
            n0   = mq.size();
            pop  = (n0 > 0) && m_tready;
            lst  = (n0 > 0) && (m_beats == PKT - 1 || m_fl == 1);
            cap  = en && pc_valid && !drop_instr;
            room = (n0 < DEPTH) || pop;
            if (pop) begin
                void'(mq.pop_front());
                if (lst) begin
                    m_beats = 0;
                    m_fl    = 0;
                end else begin
                    m_beats++;
                    if (m_fl > 0) m_fl--;
                end
            end
            if (flush && mq.size() > 0) m_fl = mq.size();
            if (cap) begin
                if (room) mq.push_back({pc, instr});
                else begin
                    m_ovf = 1'b1;
                    if (m_loss < 64'hFFFF_FFFF) m_loss++;
                end
            end
`ifdef TRACE_OVERFLOW_MARKER_EN
            else if (room && m_loss > 0) begin
                lv = m_loss[IW-1:0];
                mq.push_back({{PW{1'b1}}, lv});
                m_loss = 0;
            end
`endif
        end
    end

    function automatic logic [DW-1:0] exp_data();
        return (mq.size() > 0) ? mq[0] : '0;
    endfunction

    function automatic logic exp_last();
        return (mq.size() > 0) && (m_beats == PKT - 1 || m_fl == 1);
    endfunction

    task automatic idle_inputs();
        en         = 1'b1;
        pc_valid   = 1'b0;
        drop_instr = 1'b0;
        flush      = 1'b0;
        pc         = '0;
        instr      = '0;
    endtask

    task automatic rand_item();
        pc_valid = 1'b1;
        pc       = {$urandom, $urandom};
        instr    = $urandom;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        m_tready = 1'b0;
        idle_inputs();
        rand_item();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_tvalid got=%b want=0", m_tvalid);
        end
        checks++;
        if (m_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_tlast got=%b want=0", m_tlast);
        end
        checks++;
        if (m_tdata !== '0) begin
            errors++;
            $display("FAIL reset_tdata got=%h want=0", m_tdata);
        end
        checks++;
        if (fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_count got=%0d want=0", fifo_count);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow got=%b want=0", overflow);
        end
        rst_n = 1'b1;
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_in_order();
        int beat = 0;
        int tl_n = 0;
        int tl_pos = -1;
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) rand_item();
            else idle_inputs();
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (m_tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL first_latency tvalid=%b want=1", m_tvalid);
                end
            end
            checks++;
            if (m_tvalid !== (mq.size() > 0) || m_tdata !== exp_data() ||
                m_tlast !== exp_last() || fifo_count !== 5'(mq.size())) begin
                errors++;
                $display("FAIL in_order cyc=%0d v=%b/%b d=%h/%h l=%b/%b c=%0d/%0d",
                         i, m_tvalid, mq.size() > 0, m_tdata, exp_data(),
                         m_tlast, exp_last(), fifo_count, mq.size());
            end
            if (m_tvalid) begin
                if (m_tlast) begin
                    tl_n++;
                    tl_pos = beat;
                end
                beat++;
            end
        end
        checks++;
        if (beat != 8 || tl_n != 1 || tl_pos != 7) begin
            errors++;
            $display("FAIL in_order_pkt beats=%0d lasts=%0d pos=%0d want 8/1/7",
                     beat, tl_n, tl_pos);
        end
    endtask

    task automatic test_filter();
        do_reset();
        for (int i = 0; i < 70; i++) begin
            m_tready = ($urandom_range(0, 3) != 0);
            if (i < 40) begin
                rand_item();
                en         = 1'b1;
                drop_instr = i[0];
            end else begin
                rand_item();
                en       = 1'b0;
                m_tready = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (m_tvalid !== (mq.size() > 0) || m_tdata !== exp_data() ||
                m_tlast !== exp_last() || fifo_count !== 5'(mq.size()) ||
                overflow !== m_ovf) begin
                errors++;
                $display("FAIL filter cyc=%0d v=%b d=%h/%h l=%b/%b c=%0d/%0d",
                         i, m_tvalid, m_tdata, exp_data(), m_tlast,
                         exp_last(), fifo_count, mq.size());
            end
        end
        checks++;
        if (m_tvalid !== 1'b0 || fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL en_off v=%b c=%0d want 0/0", m_tvalid, fifo_count);
        end
        idle_inputs();
    endtask

    task automatic test_overflow();
        logic [DW-1:0] first;
        logic [DW-1:0] last_d;
        logic [DW-1:0] mark;
        int            nb;
        do_reset();
        m_tready = 1'b0;
        first    = '0;
        for (int i = 0; i < 20; i++) begin
            rand_item();
            if (i == 0) first = {pc, instr};
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (fifo_count !== 5'd16) begin
            errors++;
            $display("FAIL full_count got=%0d want=16", fifo_count);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_overflow got=%b want=1", overflow);
        end
        checks++;
        if (m_tdata !== first || m_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL full_stable d=%h want=%h v=%b",
                     m_tdata, first, m_tvalid);
        end
        m_tready = 1'b1;
        nb       = 0;
        last_d   = '0;
        for (int i = 0; i < 24; i++) begin
            if (m_tvalid) begin
                nb++;
                last_d = m_tdata;
            end
            @(negedge clk);
            checks++;
            if (m_tvalid !== (mq.size() > 0) || m_tdata !== exp_data() ||
                m_tlast !== exp_last() || fifo_count !== 5'(mq.size())) begin
                errors++;
                $display("FAIL drain cyc=%0d v=%b d=%h/%h l=%b/%b c=%0d/%0d",
                         i, m_tvalid, m_tdata, exp_data(), m_tlast,
                         exp_last(), fifo_count, mq.size());
            end
        end
`ifdef TRACE_OVERFLOW_MARKER_EN
        mark = {{PW{1'b1}}, 32'd4};
        checks++;
        if (nb != 17 || last_d !== mark) begin
            errors++;
            $display("FAIL marker beats=%0d want=17 d=%h want=%h",
                     nb, last_d, mark);
        end
`else
        mark = '0;
        checks++;
        if (nb != 16 || last_d === mark) begin
            errors++;
            $display("FAIL drain_beats got=%0d want=16", nb);
        end
`endif
    endtask

    task automatic test_flush();
        int          beat = 0;
        logic [4:0]  pat  = '0;
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_item();
            @(negedge clk);
        end
        idle_inputs();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_item();
            @(negedge clk);
        end
        idle_inputs();
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (m_tvalid && beat < 5) begin
                pat[beat] = m_tlast;
                beat++;
            end
            @(negedge clk);
            checks++;
            if (m_tvalid !== (mq.size() > 0) || m_tdata !== exp_data() ||
                m_tlast !== exp_last()) begin
                errors++;
                $display("FAIL flush_beat cyc=%0d d=%h/%h l=%b/%b",
                         i, m_tdata, exp_data(), m_tlast, exp_last());
            end
        end
        checks++;
        if (beat != 5 || pat !== 5'b00100) begin
            errors++;
            $display("FAIL flush_pkt beats=%0d last_pattern=%b want 5/00100",
                     beat, pat);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rand_item();
            @(negedge clk);
        end
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_item();
            @(negedge clk);
            checks++;
            if (fifo_count !== 5'd16 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL full_pop cyc=%0d c=%0d ovf=%b want 16/0",
                         i, fifo_count, overflow);
            end
        end
        idle_inputs();
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int beat = 0;
        int tl_n = 0;
        int tl_pos = -1;
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rand_item();
            @(negedge clk);
        end
        idle_inputs();
        m_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        m_tready = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (m_tvalid !== 1'b0 || fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset v=%b c=%0d want 0/0", m_tvalid, fifo_count);
        end
        m_tready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) rand_item();
            else idle_inputs();
            @(negedge clk);
            if (m_tvalid) begin
                if (m_tlast) begin
                    tl_n++;
                    tl_pos = beat;
                end
                beat++;
            end
        end
        checks++;
        if (beat != 8 || tl_n != 1 || tl_pos != 7) begin
            errors++;
            $display("FAIL post_reset_pkt beats=%0d lasts=%0d pos=%0d want 8/1/7",
                     beat, tl_n, tl_pos);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            en         = ($urandom_range(0, 7) != 0);
            pc_valid   = $urandom_range(0, 1);
            drop_instr = ($urandom_range(0, 3) == 0);
            pc         = {$urandom, $urandom};
            instr      = $urandom;
            flush      = ($urandom_range(0, 9) == 0);
            m_tready   = (i % 100 < 50) ? ($urandom_range(0, 3) != 0)
                                        : ($urandom_range(0, 3) == 0);
            @(negedge clk);
            checks++;
            if (m_tvalid !== (mq.size() > 0) || m_tdata !== exp_data() ||
                m_tlast !== exp_last() || fifo_count !== 5'(mq.size()) ||
                overflow !== m_ovf) begin
                errors++;
                $display("FAIL random cyc=%0d v=%b d=%h/%h l=%b/%b c=%0d/%0d o=%b/%b",
                         i, m_tvalid, m_tdata, exp_data(), m_tlast, exp_last(),
                         fifo_count, mq.size(), overflow, m_ovf);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_filter();
        test_overflow();
        test_flush();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
